// File: rtl/imem_pkg.sv
// Shared constants and types for the instruction-memory ROM controller.
// The build option IMEM_PREFETCH_EN (see imem_rom_ctrl) does not affect this package.
package imem_pkg;

    // SLL $0,$0,0 encodes as all zeros; it is returned for every rejected fetch
    localparam logic [31:0] NOP_WORD  = 32'h0000_0000;

    // CPU-view address of ROM byte 0; the controller itself only sees offsets
    localparam logic [31:0] TEXT_BASE = 32'h0040_0000;

    // The single non-NOP word of the current program image (word index 5)
    localparam logic [31:0] IMG_WORD5 = 32'h0040_8010;

    // Wait-state counter width (WAIT_CYCLES ranges over 0..15)
    localparam int CNT_W = 4;

    // Byte-offset bits below the word index
    localparam int BYTE_OFS_W = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } imem_state_e;

endpackage

// File: rtl/imem_rom_table.sv
// Combinational program image: word index in, instruction word out.
// Words 0..4 are NOP, word 5 carries the image word, everything else is NOP.
module imem_rom_table
    import imem_pkg::*;
#(
    parameter int IDX_W  = 12,
    parameter int DATA_W = 32
) (
    input  logic [IDX_W-1:0]  idx,
    output logic [DATA_W-1:0] word
);

    // Lookup decoded on the full index width so no alias can hit word 5
    always_comb begin
        word = DATA_W'(NOP_WORD);
        if (idx == IDX_W'(5)) begin
            word = DATA_W'(IMG_WORD5);
        end
    end

endmodule

// File: rtl/imem_rom_ctrl.sv
// Clocked instruction ROM controller: req/ready fetch handshake, WAIT_CYCLES
// wait states, one registered rvalid/rdata/err response per accepted request.
// Handshake: a request is taken on a rising edge where req=1 and ready=1;
// req while ready=0 is ignored. rvalid is a one-cycle pulse and rdata/err
// are only meaningful while rvalid=1.
// Build option: define IMEM_PREFETCH_EN to add a one-entry sequential
// prefetch buffer (pf_idx/pf_data/pf_valid) filled while the block is idle.
// Current FSM state is visible on state_q for external checkers.
module imem_rom_ctrl
    import imem_pkg::*;
#(
    parameter int ADDR_W      = 14,
    parameter int DATA_W      = 32,
    parameter int DEPTH       = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req,
    input  logic [ADDR_W-1:0] addr,
    output logic              ready,
    output logic [DATA_W-1:0] rdata,
    output logic              rvalid,
    output logic              err
);

    localparam int IDX_W = ADDR_W - BYTE_OFS_W;
    localparam logic [31:0]      DEPTH_U   = 32'(DEPTH);
    localparam logic [CNT_W-1:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1) : '0;

    imem_state_e       state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] rdata_q;
    logic              err_q;

    logic              accept;
    logic [IDX_W-1:0]  req_idx, lat_idx, tbl_idx;
    logic [DATA_W-1:0] tbl_word;
    logic [DATA_W-1:0] resp_data;
    logic              resp_err;

    // Prefetch interface into the main FSM (tied off when the option is absent)
    logic              pf_hit;
    logic              pf_follow;
    logic [CNT_W-1:0]  pf_follow_cnt;
    logic [DATA_W-1:0] pf_data;

    function automatic logic fetch_bad(input logic [ADDR_W-1:0] a);
        return (a[1:0] != 2'b00) || (32'(a[ADDR_W-1:BYTE_OFS_W]) >= DEPTH_U);
    endfunction

    assign accept  = req & ready;
    assign req_idx = addr[ADDR_W-1:BYTE_OFS_W];
    assign lat_idx = addr_q[ADDR_W-1:BYTE_OFS_W];

    imem_rom_table #(.IDX_W(IDX_W), .DATA_W(DATA_W)) u_table (
        .idx  (tbl_idx),
        .word (tbl_word)
    );

    // State register and wait counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic: accept from IDLE or RESP, count down in WAIT
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE, RESP: begin
                if (accept) begin
                    if (pf_hit || (pf_follow && pf_follow_cnt == '0) || WAIT_CYCLES == 0) begin
                        state_d = RESP;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = pf_follow ? (pf_follow_cnt - CNT_W'(1)) : WAIT_LOAD;
                    end
                end else if (state_q == RESP) begin
                    state_d = IDLE;
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: ready everywhere but WAIT, rvalid only in RESP
    always_comb begin
        ready  = (state_q != WAIT);
        rvalid = (state_q == RESP);
    end

    // Response source: live request when answering at once, else the latched one
    always_comb begin
        tbl_idx  = accept ? req_idx : lat_idx;
        resp_err = accept ? fetch_bad(addr) : fetch_bad(addr_q);
        if (resp_err) begin
            resp_data = DATA_W'(NOP_WORD);
        end else if (accept && pf_hit) begin
            resp_data = pf_data;
        end else begin
            resp_data = tbl_word;
        end
    end

    // Address latch and registered response, loaded on entry to RESP
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q  <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            if (accept) begin
                addr_q <= addr;
            end
            if (state_d == RESP) begin
                rdata_q <= resp_data;
                err_q   <= resp_err;
            end
        end
    end

    assign rdata = rdata_q;
    assign err   = err_q;

`ifdef IMEM_PREFETCH_EN
    logic              pf_valid_q;
    logic              pf_busy_q;
    logic [IDX_W-1:0]  pf_idx_q;
    logic [CNT_W-1:0]  pf_cnt_q;
    logic [DATA_W-1:0] pf_data_q;
    logic [DATA_W-1:0] pf_word;
    logic [IDX_W-1:0]  next_idx;
    logic              next_ok;
    logic              req_aligned;

    assign next_idx    = lat_idx + IDX_W'(1);
    assign next_ok     = (32'(lat_idx) + 32'd1) < DEPTH_U;
    assign req_aligned = (addr[1:0] == 2'b00);

    // An aligned request for the buffered or in-flight index
    assign pf_hit        = pf_valid_q && req_aligned && (req_idx == pf_idx_q);
    assign pf_follow     = pf_busy_q && req_aligned && (req_idx == pf_idx_q);
    assign pf_follow_cnt = pf_cnt_q;
    assign pf_data       = pf_data_q;

    imem_rom_table #(.IDX_W(IDX_W), .DATA_W(DATA_W)) u_pf_table (
        .idx  (pf_idx_q),
        .word (pf_word)
    );

    // Prefetch buffer: start after a clean idle response, fill after the countdown
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pf_valid_q <= 1'b0;
            pf_busy_q  <= 1'b0;
            pf_idx_q   <= '0;
            pf_cnt_q   <= '0;
            pf_data_q  <= '0;
        end else begin
            if (state_q == RESP && err_q) begin
                pf_valid_q <= 1'b0;
            end
            if (accept) begin
                // A matching request takes over the countdown in the main FSM
                pf_busy_q <= 1'b0;
            end else if (state_q == RESP && !err_q && next_ok) begin
                pf_idx_q   <= next_idx;
                pf_valid_q <= 1'b0;
                pf_busy_q  <= 1'b1;
                pf_cnt_q   <= WAIT_LOAD;
            end else if (pf_busy_q && state_q == IDLE) begin
                if (pf_cnt_q == '0) begin
                    pf_data_q  <= pf_word;
                    pf_valid_q <= 1'b1;
                    pf_busy_q  <= 1'b0;
                end else begin
                    pf_cnt_q <= pf_cnt_q - CNT_W'(1);
                end
            end
        end
    end
`else
    assign pf_hit        = 1'b0;
    assign pf_follow     = 1'b0;
    assign pf_follow_cnt = '0;
    assign pf_data       = '0;
`endif

endmodule

// File: tb/tb_imem_rom_ctrl.sv
// Bench for imem_rom_ctrl: one instance with WAIT_CYCLES=2, one with 0.
// Expected responses (cycle, err, data) are queued at accept time and
// popped by per-instance monitors on the falling edge.
module tb_imem_rom_ctrl;

    localparam int EW = 49;
    localparam logic [31:0] W5 = 32'h0040_8010;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        rst_n, rst0_n;
    logic        req, req0;
    logic [13:0] addr, addr0;
    logic        ready, ready0;
    logic [31:0] rdata, rdata0;
    logic        rvalid, rvalid0;
    logic        err, err0;

    imem_rom_ctrl #(.ADDR_W(14), .DATA_W(32), .DEPTH(1024), .WAIT_CYCLES(2)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .addr(addr),
        .ready(ready), .rdata(rdata), .rvalid(rvalid), .err(err)
    );

    imem_rom_ctrl #(.ADDR_W(14), .DATA_W(32), .DEPTH(1024), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rst_n(rst0_n), .req(req0), .addr(addr0),
        .ready(ready0), .rdata(rdata0), .rvalid(rvalid0), .err(err0)
    );

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;
    int ready0_low = 0;
    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] exp0_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    logic [EW-1:0] e2;
    always @(negedge clk) begin
        if (rst_n === 1'b1 && rvalid === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("w2_unexpected_rvalid", 32'd1, 32'd0);
            end else begin
                e2 = exp_q.pop_front();
                chk("w2_rdata", rdata, e2[31:0]);
                chk("w2_err", {31'b0, err}, {31'b0, e2[32]});
                chk("w2_resp_cycle", {16'b0, cyc[15:0]}, {16'b0, e2[48:33]});
            end
        end
    end

    logic [EW-1:0] e0;
    always @(negedge clk) begin
        if (rst0_n === 1'b1) begin
            if (ready0 !== 1'b1) ready0_low++;
            if (rvalid0 === 1'b1) begin
                if (exp0_q.size() == 0) begin
                    chk("w0_unexpected_rvalid", 32'd1, 32'd0);
                end else begin
                    e0 = exp0_q.pop_front();
                    chk("w0_rdata", rdata0, e0[31:0]);
                    chk("w0_err", {31'b0, err0}, {31'b0, e0[32]});
                    chk("w0_resp_cycle", {16'b0, cyc[15:0]}, {16'b0, e0[48:33]});
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Raise req on the WAIT_CYCLES=2 instance, hold it until accepted, queue
    // the expected response lat cycles after the accepting edge.
    task automatic issue(input logic [13:0] a, input logic [31:0] d, input logic e,
                         input int lat, input bit push);
        int n;
        req  = 1'b1;
        addr = a;
        n = 0;
        while (ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (ready !== 1'b1) begin
            chk("ready_timeout", {31'b0, ready}, 32'd1);
        end else begin
            @(posedge clk);
            #1;
            if (push) exp_q.push_back({16'(cyc + lat), e, d});
            @(negedge clk);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("w2_drain", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic drain0();
        int n;
        n = 0;
        while (exp0_q.size() != 0 && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("w0_drain", 32'(exp0_q.size()), 32'd0);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    initial begin
        req = 1'b0; addr = '0; req0 = 1'b0; addr0 = '0;
        rst_n = 1'b0; rst0_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ready", {31'b0, ready}, 32'd1);
        chk("rst_rvalid", {31'b0, rvalid}, 32'd0);
        chk("rst_err", {31'b0, err}, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst0_ready", {31'b0, ready0}, 32'd1);
        chk("rst0_rvalid", {31'b0, rvalid0}, 32'd0);
        chk("rst0_err", {31'b0, err0}, 32'd0);
        chk("rst0_rdata", rdata0, 32'd0);
        rst_n = 1'b1; rst0_n = 1'b1;
        @(negedge clk);

        // Single fetch of word 5, ready low for exactly two cycles
        issue(14'h014, W5, 1'b0, 2, 1'b1);
        req = 1'b0;
        chk("single_ready_c0", {31'b0, ready}, 32'd0);
        @(negedge clk);
        chk("single_ready_c1", {31'b0, ready}, 32'd0);
        @(negedge clk);
        chk("single_ready_c2", {31'b0, ready}, 32'd1);
        drain();

        // Reset during WAIT: fetch discarded, outputs cleared, next fetch normal
        issue(14'h014, W5, 1'b0, 2, 1'b0);
        req = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        chk("abort_ready", {31'b0, ready}, 32'd1);
        chk("abort_rvalid", {31'b0, rvalid}, 32'd0);
        chk("abort_err", {31'b0, err}, 32'd0);
        chk("abort_rdata", rdata, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            chk("abort_no_rvalid", {31'b0, rvalid}, 32'd0);
        end
        issue(14'h014, W5, 1'b0, 2, 1'b1);
        req = 1'b0;
        drain();

        // Back-to-back with req held: responses three cycles apart
        issue(14'h000, 32'd0, 1'b0, 2, 1'b1);
        issue(14'h004, 32'd0, 1'b0, 2, 1'b1);
        issue(14'h014, W5, 1'b0, 2, 1'b1);
        req = 1'b0;
        drain();

        // Error fetches: misaligned, out of range, and both at once
        issue(14'h016, 32'd0, 1'b1, 2, 1'b1);
        req = 1'b0;
        drain();
        issue(14'h1000, 32'd0, 1'b1, 2, 1'b1);
        req = 1'b0;
        drain();
        issue(14'h1002, 32'd0, 1'b1, 2, 1'b1);
        req = 1'b0;
        drain();
        issue(14'h0FFC, 32'd0, 1'b0, 2, 1'b1);
        req = 1'b0;
        drain();

        // Zero wait states: a new request every cycle, one response per cycle
        for (int i = 0; i < 10; i++) begin
            req0  = 1'b1;
            addr0 = (i == 9) ? 14'h1000 : 14'(i * 4);
            chk("w0_ready_stream", {31'b0, ready0}, 32'd1);
            @(posedge clk);
            #1;
            exp0_q.push_back({16'(cyc), (i == 9), (i == 5) ? W5 : 32'd0});
            @(negedge clk);
        end
        req0 = 1'b0;
        drain0();
        chk("w0_ready_never_low", 32'(ready0_low), 32'd0);

`ifdef IMEM_PREFETCH_EN
        // Sequential hit answers the cycle after accept; a miss pays full latency
        issue(14'h010, 32'd0, 1'b0, 2, 1'b1);
        req = 1'b0;
        drain();
        repeat (3) @(negedge clk);
        issue(14'h014, W5, 1'b0, 0, 1'b1);
        req = 1'b0;
        drain();
        repeat (3) @(negedge clk);
        issue(14'h000, 32'd0, 1'b0, 2, 1'b1);
        req = 1'b0;
        drain();
`endif

        repeat (4) @(negedge clk);
        chk("final_w2_queue", 32'(exp_q.size()), 32'd0);
        chk("final_w0_queue", 32'(exp0_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/imem_rom_ctrl.md
Name: imem_rom_ctrl

Overview:
Parametrised, clocked instruction-memory ROM controller for the MIPS datapath. It replaces the purely combinational simulation ROM.
- Accepts byte-addressed fetch requests through a req/ready handshake.
- Models a configurable access latency.
- Flags misaligned and out-of-range fetches.
- Returns one 32-bit instruction word per accepted request.
- Sits between the fetch stage and a combinational ROM table sub-module.

Parameters:
ADDR_W, 14, byte-address width of addr.
DATA_W, 32, instruction word width.
DEPTH, 1024, number of ROM words; valid word indices are 0..DEPTH-1.
WAIT_CYCLES, 2, extra access wait states (0..15).

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
req  in  1  fetch request; sampled only when ready=1
addr  in  ADDR_W  byte address of the fetch
ready  out  1  controller can accept a request this cycle
rdata  out  DATA_W  fetched instruction; meaningful only while rvalid=1
rvalid  out  1  one-cycle pulse, rdata/err valid
err  out  1  with rvalid: misaligned (addr[1:0]!=0) or word index >= DEPTH

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, ready=1, rvalid=0, err=0, rdata=0.
  - Wait counter cleared.
  - Any in-flight fetch is discarded, with no rvalid afterwards.
- Word index = addr[ADDR_W-1:2]. The lookup uses the full index width; no truncation.
- Accept: req & ready at a rising edge latches addr. The state then goes to WAIT, or to RESP when WAIT_CYCLES=0.
- FSM:
  - IDLE: ready=1. On accept, go to WAIT (counter=WAIT_CYCLES-1) or to RESP.
  - WAIT: ready=0. The counter decrements each cycle; at 0, go to RESP.
  - RESP: rvalid=1 for exactly one cycle and ready=1. An accept in this cycle starts the next fetch directly (WAIT or RESP); otherwise go to IDLE.
- Latency: rvalid is asserted WAIT_CYCLES+1 cycles after the accepting edge.
- Throughput: back-to-back issue gives one word per WAIT_CYCLES+1 cycles.
- Error cases:
  - Misaligned or out-of-range: rvalid=1, err=1, rdata=0 (NOP, SLL $0,$0,0).
  - Both conditions at once still produce a single err.
- rdata/err are registered outputs. They are held at their last value while rvalid=0, and the bench must not check them then.
- req while ready=0 is ignored; the fetch stage must hold req until it sees ready.
- rst_n deasserting mid-WAIT returns the block to IDLE; the aborted fetch never responds.

Optional Feature:
IMEM_PREFETCH_EN.
- Defined:
  - Sequential prefetch is enabled. After each non-error response, while in IDLE, the block fetches word index+1 in the background using the same WAIT_CYCLES countdown into a one-entry buffer (pf_idx, pf_data, pf_valid).
  - A request whose index equals pf_idx with pf_valid=1 is a hit: rvalid is asserted next cycle, regardless of WAIT_CYCLES.
  - A request for pf_idx while that prefetch is still counting continues the countdown, so it responds when the countdown completes.
  - Any other request aborts the prefetch and proceeds normally.
  - The buffer is invalidated on reset and on any err response.
  - A prefetch of an index >= DEPTH is never started.
- Not defined: no buffer; every request pays full latency.

Decomposition:
- Package imem_pkg holds:
  - NOP_WORD = 32'h00000000.
  - TEXT_BASE = 32'h00400000 (documentation of the CPU-view address mapping).
  - FSM state enum {IDLE, WAIT, RESP}.
  - Width constants.
- Sub-module imem_rom_table: combinational word-index to DATA_W lookup holding the program image.
  - Words 0..4 = 32'h00000000.
  - Word 5 = 32'h00408010.
  - All other indices = NOP_WORD.
- The controller instantiates one table (two read ports, or two instances, when IMEM_PREFETCH_EN is defined).

Test Plan:
- Reset, WAIT_CYCLES=2, single req addr=0x014 -> rvalid at edge +3 with rdata=32'h00408010, err=0; ready low for exactly 2 cycles.
- Back-to-back req addr=0x000,0x004,0x014 held continuously -> three rvalid pulses spaced 3 cycles apart, rdata 0,0,32'h00408010.
- Misaligned addr=0x016 -> rvalid with err=1, rdata=0; out-of-range addr=0x1000 (index 1024) -> err=1, rdata=0.
- WAIT_CYCLES=0, continuous req incrementing by 4 -> rvalid every cycle, ready never low.
- rst_n pulsed low during WAIT of fetch addr=0x014 -> no rvalid afterwards, outputs zero, next req served normally.
- IMEM_PREFETCH_EN, WAIT_CYCLES=2:
  - req 0x010, then idle 3 cycles, then req 0x014 -> second rvalid one cycle after accept, with 32'h00408010.
  - req 0x000 in the same situation -> full 3-cycle latency.
